// File: rtl/sha1_block_arbiter.sv
// sha1_block_arbiter: round-robin arbiter that shares one sha1_block core among NUM_REQ requesters.
// Latency: grant is registered one edge after req is seen in IDLE; core_start follows one cycle later;
//          resp_valid is registered one edge after core_done. Backpressure: req is a level held until grant.
// Ports: req/req_context/req_block (requester side), grant/resp_valid/resp_context (handshake and result),
//        busy/timeout_err (status), core_start/core_context_in/core_block/core_done/core_context_out (core side).
module sha1_block_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*160-1:0] req_context,
  input  logic [NUM_REQ*512-1:0] req_block,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [159:0]           resp_context,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   core_start,
  output logic [159:0]           core_context_in,
  output logic [511:0]           core_block,
  input  logic                   core_done,
  input  logic [159:0]           core_context_out
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [OW-1:0]   last_owner;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   win;
  logic            win_vld;
  logic [4:0]      idx;
  logic [CW-1:0]   cnt;
  logic [CW:0]     cnt_inc;
  logic            load;
  logic            start_nxt;
  logic            finish_ok;
  logic            finish_tmo;

  // Round-robin search: first set req bit starting just above last_owner.
  // idx is 5 bits so last_owner + k (max 15 + 16) cannot overflow before the wrap.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {{(5-OW){1'b0}}, last_owner} + 5'(k);
      if (idx >= 5'(NUM_REQ)) begin
        idx = idx - 5'(NUM_REQ);
      end
      if (!win_vld && req[idx[OW-1:0]]) begin
        win_vld = 1'b1;
        win     = idx[OW-1:0];
      end
    end
  end

  // Counter value the current BUSY cycle would reach; compared against TIMEOUT
  // so the TIMEOUT-th BUSY cycle without core_done is the one that drops the job.
  assign cnt_inc = {1'b0, cnt} + (CW+1)'(1);

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    start_nxt  = 1'b0;
    finish_ok  = 1'b0;
    finish_tmo = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        start_nxt = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        // core_done is checked first so a response on the limit cycle wins.
        if (core_done) begin
          finish_ok = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_inc == (CW+1)'(TIMEOUT)) begin
          finish_tmo = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_owner      <= OW'(NUM_REQ - 1);
      owner           <= '0;
      cnt             <= '0;
      grant           <= '0;
      resp_valid      <= '0;
      resp_context    <= '0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
      core_start      <= 1'b0;
      core_context_in <= '0;
      core_block      <= '0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != IDLE);
      core_start <= start_nxt;
      grant      <= load ? (NUM_REQ'(1) << win) : '0;
      resp_valid <= finish_ok ? (NUM_REQ'(1) << owner) : '0;

      if (load) begin
        owner           <= win;
        core_context_in <= req_context[160*win +: 160];
        core_block      <= req_block[512*win +: 512];
      end

      if (state == START) begin
        cnt <= '0;
      end else if (state == BUSY && !core_done) begin
        cnt <= cnt_inc[CW-1:0];
      end

      if (finish_ok) begin
        resp_context <= core_context_out;
      end

      if (finish_ok || finish_tmo) begin
        last_owner <= owner;
      end

      if (finish_tmo) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sha1_block_arbiter.sv
// Self-checking bench for sha1_block_arbiter: the bench plays the sha1_block core.
// Per-cycle vector table for arbitration and handshakes, then hand-written sequences
// for long latency, timeout, timeout boundary and reset mid-job.
module tb_sha1_block_arbiter;
  localparam int N = 4;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*160-1:0] req_context;
  logic [N*512-1:0] req_block;
  logic [N-1:0]     grant;
  logic [N-1:0]     resp_valid;
  logic [159:0]     resp_context;
  logic             busy;
  logic             timeout_err;
  logic             core_start;
  logic [159:0]     core_context_in;
  logic [511:0]     core_block;
  logic             core_done;
  logic [159:0]     core_context_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  sha1_block_arbiter #(.NUM_REQ(N), .TIMEOUT(255)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .req_context      (req_context),
    .req_block        (req_block),
    .grant            (grant),
    .resp_valid       (resp_valid),
    .resp_context     (resp_context),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .core_start       (core_start),
    .core_context_in  (core_context_in),
    .core_block       (core_block),
    .core_done        (core_done),
    .core_context_out (core_context_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [159:0] ctx_of(input int i);
    logic [31:0] w;
    w = 32'h1000_0000 + 32'(i);
    return {5{w}};
  endfunction

  function automatic logic [511:0] blk_of(input int i);
    logic [31:0] w;
    w = 32'h2000_0000 + 32'(i);
    return {16{w}};
  endfunction

  function automatic logic [159:0] resp_of(input int k);
    logic [31:0] w;
    w = 32'hA5A5_0000 + 32'(k);
    return (k == 0) ? 160'd0 : {5{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic       done;
    int         ck;
    logic [3:0] eg;
    logic [3:0] erv;
    logic       es;
    logic       eb;
    logic       et;
    int         erk;
  } vec_t;

  function automatic vec_t mkv(input logic rst, input logic [3:0] rq, input logic done, input int ck,
                               input logic [3:0] eg, input logic [3:0] erv, input logic es,
                               input logic eb, input logic et, input int erk);
    vec_t v;
    v.rst = rst; v.rq = rq; v.done = done; v.ck = ck;
    v.eg = eg; v.erv = erv; v.es = es; v.eb = eb; v.et = et; v.erk = erk;
    return v;
  endfunction

  vec_t tv[25];

  initial begin
    int cur_owner;
    int bad;

    rst_n = 1'b0;
    req = '0;
    core_done = 1'b0;
    core_context_out = '0;
    for (int i = 0; i < N; i++) begin
      req_context[160*i +: 160] = ctx_of(i);
      req_block[512*i +: 512]   = blk_of(i);
    end

    //             rst  req     done ck | grant   rv      st  bsy err resp
    tv[0]  = mkv(1'b0, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0);
    tv[1]  = mkv(1'b1, 4'b0001, 1'b0, 0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 0);
    tv[2]  = mkv(1'b1, 4'b0000, 1'b1, 0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 0); // done in START ignored
    tv[3]  = mkv(1'b1, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0);
    tv[4]  = mkv(1'b1, 4'b0000, 1'b1, 1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1);
    tv[5]  = mkv(1'b1, 4'b0000, 1'b1, 2, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1); // done in IDLE ignored
    tv[6]  = mkv(1'b1, 4'b1111, 1'b0, 0, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 1);
    tv[7]  = mkv(1'b1, 4'b1111, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1);
    tv[8]  = mkv(1'b1, 4'b1111, 1'b1, 3, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 3);
    tv[9]  = mkv(1'b1, 4'b1111, 1'b0, 0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 3);
    tv[10] = mkv(1'b1, 4'b1111, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 3);
    tv[11] = mkv(1'b1, 4'b1111, 1'b1, 4, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0, 4);
    tv[12] = mkv(1'b1, 4'b1111, 1'b0, 0, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 4);
    tv[13] = mkv(1'b1, 4'b1111, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 4);
    tv[14] = mkv(1'b1, 4'b1111, 1'b1, 5, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 5);
    tv[15] = mkv(1'b1, 4'b1111, 1'b0, 0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 5);
    tv[16] = mkv(1'b1, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 5);
    tv[17] = mkv(1'b1, 4'b0000, 1'b1, 6, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 6);
    tv[18] = mkv(1'b1, 4'b0100, 1'b0, 0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 6);
    tv[19] = mkv(1'b1, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 6);
    tv[20] = mkv(1'b1, 4'b0000, 1'b1, 7, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0, 7);
    tv[21] = mkv(1'b1, 4'b0101, 1'b0, 0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 7); // wrap past 3 to 0
    tv[22] = mkv(1'b1, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 7);
    tv[23] = mkv(1'b1, 4'b0000, 1'b1, 8, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 8);
    tv[24] = mkv(1'b1, 4'b0000, 1'b0, 0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 8);

    cur_owner = 0;
    for (int i = 0; i < 25; i++) begin
      rst_n            = tv[i].rst;
      req              = tv[i].rq;
      core_done        = tv[i].done;
      core_context_out = resp_of(tv[i].ck);
      tick();
      chk($sformatf("row%0d grant", i), 512'(grant), 512'(tv[i].eg));
      chk($sformatf("row%0d resp_valid", i), 512'(resp_valid), 512'(tv[i].erv));
      chk($sformatf("row%0d core_start", i), 512'(core_start), 512'(tv[i].es));
      chk($sformatf("row%0d busy", i), 512'(busy), 512'(tv[i].eb));
      chk($sformatf("row%0d timeout_err", i), 512'(timeout_err), 512'(tv[i].et));
      chk($sformatf("row%0d resp_context", i), 512'(resp_context), 512'(resp_of(tv[i].erk)));
      for (int b = 0; b < N; b++) begin
        if (tv[i].eg[b]) cur_owner = b;
      end
      if (tv[i].es) begin
        chk($sformatf("row%0d core_context_in", i), 512'(core_context_in), 512'(ctx_of(cur_owner)));
        chk($sformatf("row%0d core_block", i), core_block, blk_of(cur_owner));
      end
    end
    core_done = 1'b0;
    core_context_out = '0;

    // Long latency job; requester inputs change while the job is in flight.
    req = 4'b0001;
    tick();
    chk("lat grant", 512'(grant), 512'(4'b0001));
    req = 4'b0000;
    req_block[511:0]   = '1;
    req_context[159:0] = '0;
    tick();
    chk("lat core_start", 512'(core_start), 512'd1);
    chk("lat core_block", core_block, blk_of(0));
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (resp_valid != 0 || core_start || grant != 0 || !busy ||
          core_block !== blk_of(0) || core_context_in !== ctx_of(0)) bad++;
    end
    chk("lat hold", 512'(bad), 512'd0);
    core_done = 1'b1;
    core_context_out = resp_of(9);
    tick();
    core_done = 1'b0;
    chk("lat resp_valid", 512'(resp_valid), 512'(4'b0001));
    chk("lat resp_context", 512'(resp_context), 512'(resp_of(9)));
    chk("lat busy", 512'(busy), 512'd0);
    req_block[511:0]   = blk_of(0);
    req_context[159:0] = ctx_of(0);

    // Timeout: core_done withheld for 255 BUSY cycles.
    req = 4'b0010;
    tick();
    chk("tmo grant", 512'(grant), 512'(4'b0010));
    req = 4'b0000;
    tick();
    chk("tmo core_start", 512'(core_start), 512'd1);
    bad = 0;
    for (int c = 0; c < 254; c++) begin
      tick();
      if (resp_valid != 0 || timeout_err || !busy) bad++;
    end
    chk("tmo before limit", 512'(bad), 512'd0);
    tick();
    chk("tmo timeout_err", 512'(timeout_err), 512'd1);
    chk("tmo busy", 512'(busy), 512'd0);
    chk("tmo resp_valid", 512'(resp_valid), 512'd0);
    core_done = 1'b1;
    core_context_out = resp_of(10);
    tick();
    core_done = 1'b0;
    chk("late done resp_valid", 512'(resp_valid), 512'd0);
    chk("late done resp_context", 512'(resp_context), 512'(resp_of(9)));
    chk("late done busy", 512'(busy), 512'd0);
    chk("late done sticky err", 512'(timeout_err), 512'd1);
    req = 4'b0100;
    tick();
    chk("after tmo grant", 512'(grant), 512'(4'b0100));

    // Reset while BUSY abandons the job.
    req = 4'b0000;
    tick();
    tick();
    tick();
    chk("pre-reset busy", 512'(busy), 512'd1);
    rst_n = 1'b0;
    req = 4'b1000;
    tick();
    chk("rst grant", 512'(grant), 512'd0);
    chk("rst resp_valid", 512'(resp_valid), 512'd0);
    chk("rst core_start", 512'(core_start), 512'd0);
    chk("rst busy", 512'(busy), 512'd0);
    chk("rst timeout_err", 512'(timeout_err), 512'd0);
    chk("rst resp_context", 512'(resp_context), 512'd0);
    chk("rst core_block", core_block, 512'd0);
    tick();
    chk("rst held grant", 512'(grant), 512'd0);
    rst_n = 1'b1;
    core_done = 1'b1;
    core_context_out = resp_of(11);
    tick();
    chk("post-rst grant", 512'(grant), 512'(4'b1000));
    chk("post-rst resp_valid", 512'(resp_valid), 512'd0);
    core_done = 1'b0;
    req = 4'b0000;
    tick();
    chk("post-rst core_block", core_block, blk_of(3));
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("post-rst resp_valid", 512'(resp_valid), 512'(4'b1000));
    chk("post-rst resp_context", 512'(resp_context), 512'(resp_of(11)));

    // core_done on the very cycle the counter reaches the limit counts as success.
    req = 4'b0001;
    tick();
    chk("edge grant", 512'(grant), 512'(4'b0001));
    req = 4'b0000;
    tick();
    bad = 0;
    for (int c = 0; c < 254; c++) begin
      tick();
      if (resp_valid != 0 || timeout_err || !busy) bad++;
    end
    chk("edge before limit", 512'(bad), 512'd0);
    core_done = 1'b1;
    core_context_out = resp_of(12);
    tick();
    core_done = 1'b0;
    chk("edge resp_valid", 512'(resp_valid), 512'(4'b0001));
    chk("edge timeout_err", 512'(timeout_err), 512'd0);
    chk("edge resp_context", 512'(resp_context), 512'(resp_of(12)));
    chk("edge busy", 512'(busy), 512'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
